hier_node_sequencer: RTL and testbench
======================================

# hier_node_sequencer

Parametrised hierarchy node controller that launches up to NUM_CHILDREN child sub-modules and collects their completion. It generalises the fixed five-child structural node into a single block with a configurable child count, parallel or sequential launch mode, per-child enable masking, per-child timeout and error reporting. It sits between a parent node's start/done handshake and the start/done pins of its child instances, and it can be cascaded to build deeper trees.

## Interface
- NUM_CHILDREN, 5, number of child channels (1..32)
- TIMEOUT, 255, maximum cycles to wait for a launched child's done (≥1)
- CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, do not override)

- clk  in  1  sole clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  parent requests a run
- start_ready  out  1  node idle; handshake completes when start_valid && start_ready
- mode  in  1  sampled at accept: 0 = sequential, 1 = parallel
- child_en  in  NUM_CHILDREN  enable mask, sampled at accept
- child_start  out  NUM_CHILDREN  one-cycle start pulse per child
- child_done  in  NUM_CHILDREN  one-cycle completion pulse per child
- busy  out  1  run in progress
- done  out  1  one-cycle run-complete pulse
- err  out  1  valid with done: some enabled child timed out
- done_mask  out  NUM_CHILDREN  children that completed in the last run
- timeout_mask  out  NUM_CHILDREN  enabled children that did not complete in the last run

## Operation
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE: start_ready=1, busy=0. On accept, latch mode and child_en into en_q, clear done_mask and timeout_mask, and go to LAUNCH. If child_en==0, go straight to FINISH with err=0.
- LAUNCH (1 cycle):
  - Parallel: child_start=en_q.
  - Sequential: child_start = one-hot of the lowest-index bit of en_q & ~launched.
  - Set the launched bits, clear the counter, go to WAIT.
- WAIT:
  - Counter increments each cycle, saturating at TIMEOUT.
  - A child_done[i] is accepted only if child i is launched and not yet done. Accepted bits set done_mask[i].
  - Done pulses from unlaunched, disabled or already-done children are ignored.
  - Parallel: when every en_q bit is done, go to FINISH. When the counter reaches TIMEOUT first, go to FINISH with err=1.
  - Sequential: when the current child is done and enabled children remain unlaunched, go to LAUNCH. When none remain, go to FINISH. When the counter reaches TIMEOUT, abort and go to FINISH with err=1; the remaining children are never started.
- FINISH (1 cycle): done=1; err=1 iff timeout_mask≠0, where timeout_mask = en_q & ~done_mask. Then go to IDLE.
- done_mask and timeout_mask hold their values until the next accept.
- A child_done arriving in the same cycle the counter reaches TIMEOUT counts as done (done has priority over timeout).

## Timing
- Reset values: child_start=0, done=0, err=0, busy=0, done_mask=0, timeout_mask=0, state=IDLE. start_ready=0 while rst=1 and 1 from the first cycle after release.
- rst mid-run aborts at once. No done pulse and no further child_start are produced, and late child_done pulses are ignored.
- Accept at cycle T. Then LAUNCH at T+1, with child_start asserted at T+1.
- A child_done at T+1 (same cycle as its start) is ignored. The earliest legal done is at T+2.
- Parallel run: if the last done arrives at cycle D, the done pulse is at D+1 and start_ready returns at D+2.
- Sequential run: the next child's start is at D+1 after the previous child's done at D.
- Timeout: a child started at cycle S with no done → counter reaches TIMEOUT at S+TIMEOUT → done/err pulse at S+TIMEOUT+1.
- Empty mask: accept at T, done at T+1 (err=0), start_ready at T+2.
- start_ready is 0 from T+1 until the cycle after the done pulse. start_valid is ignored while busy.

## Test plan
- Parallel, child_en=5'b11111; children answer 3,5,2,7,4 cycles after start → single child_start=11111 at T+1, done at T+9, err=0, done_mask=11111.
- Sequential, child_en=5'b10110, each child answers after 2 cycles → starts 00010, 00100, 10000 each one cycle after the previous done; done once, err=0.
- TIMEOUT=8, parallel, child 3 never answers → done at S+9, err=1, timeout_mask=01000, done_mask=10111.
- Sequential, child 1 times out with child_en=00111 → child 2 is never started; timeout_mask=00110, err=1.
- Run in progress: spurious child_done on disabled child 4, plus a duplicate done on child 0 → ignored. Then rst asserted mid-WAIT → outputs return to reset values, no done pulse.
- child_en=0 → done at T+1, err=0, both masks 0. A back-to-back start_valid held high is accepted at T+2.

Source files
------------

// File: rtl/hier_node_sequencer.sv
// hier_node_sequencer
//   Hierarchy node controller. Accepts a run request from a parent node,
//   launches the enabled children (all at once or one after another), and
//   collects their completion pulses. A per-child wait budget bounds each
//   child. The run ends with a done pulse, an error flag and two result masks.
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   start_valid/start_ready : run request handshake from the parent
//   mode          : 0 = sequential, 1 = parallel (sampled at accept)
//   child_en      : per-child enable mask (sampled at accept)
//   child_start   : one-cycle start pulse per child
//   child_done    : one-cycle completion pulse per child
//   busy          : run in progress
//   done, err     : run-complete pulse, and "some enabled child timed out"
//   done_mask     : children that completed in the last run
//   timeout_mask  : enabled children that did not complete in the last run
module hier_node_sequencer #(
  parameter int NUM_CHILDREN = 5,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic                    mode,
  input  logic [NUM_CHILDREN-1:0] child_en,
  output logic [NUM_CHILDREN-1:0] child_start,
  input  logic [NUM_CHILDREN-1:0] child_done,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [NUM_CHILDREN-1:0] done_mask,
  output logic [NUM_CHILDREN-1:0] timeout_mask
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_e;

  localparam logic [NUM_CHILDREN-1:0] ONE = NUM_CHILDREN'(1);
  localparam logic [CNT_W-1:0]        TMO = CNT_W'(TIMEOUT);

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [NUM_CHILDREN-1:0] en_q, en_d;
  logic [NUM_CHILDREN-1:0] launched_q, launched_d;
  logic [NUM_CHILDREN-1:0] cur_q, cur_d;        // child(ren) started by the last LAUNCH
  logic [NUM_CHILDREN-1:0] done_mask_q, done_mask_d;
  logic [NUM_CHILDREN-1:0] tmask_q, tmask_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CHILDREN-1:0] start_c;
  logic [NUM_CHILDREN-1:0] pend;
  logic [NUM_CHILDREN-1:0] accepted;
  logic                    hit;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    en_d        = en_q;
    launched_d  = launched_q;
    cur_d       = cur_q;
    done_mask_d = done_mask_q;
    tmask_d     = tmask_q;
    cnt_d       = cnt_q;
    start_c     = '0;
    accepted    = '0;
    hit         = 1'b0;
    pend        = en_q & ~launched_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          mode_d      = mode;
          en_d        = child_en;
          launched_d  = '0;
          cur_d       = '0;
          done_mask_d = '0;
          tmask_d     = '0;
          state_d     = (child_en == '0) ? FINISH : LAUNCH;
        end
      end

      LAUNCH: begin
        // Sequential mode isolates the lowest pending bit (x & -x).
        start_c    = mode_q ? en_q : (pend & (~pend + ONE));
        launched_d = launched_q | start_c;
        cur_d      = start_c;
        cnt_d      = '0;
        state_d    = WAIT;
      end

      WAIT: begin
        accepted    = child_done & launched_q & ~done_mask_q;
        done_mask_d = done_mask_q | accepted;
        cnt_d       = (cnt_q == TMO) ? cnt_q : cnt_q + CNT_W'(1);
        hit         = (cnt_d == TMO);
        // Done is evaluated before the timeout so a completion arriving in
        // the timeout cycle still counts.
        if (mode_q) begin
          if ((en_q & ~done_mask_d) == '0) state_d = FINISH;
          else if (hit)                    state_d = FINISH;
        end else begin
          if ((cur_q & done_mask_d) != '0) state_d = (pend != '0) ? LAUNCH : FINISH;
          else if (hit)                    state_d = FINISH;
        end
        if (state_d == FINISH) tmask_d = en_q & ~done_mask_d;
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      en_q        <= '0;
      launched_q  <= '0;
      cur_q       <= '0;
      done_mask_q <= '0;
      tmask_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      en_q        <= en_d;
      launched_q  <= launched_d;
      cur_q       <= cur_d;
      done_mask_q <= done_mask_d;
      tmask_q     <= tmask_d;
      cnt_q       <= cnt_d;
    end
  end

  // Control outputs are masked by rst so an abort takes effect in the same
  // cycle rst is raised, before the registers clear on the next edge.
  assign start_ready  = (state_q == IDLE) && !rst;
  assign busy         = (state_q != IDLE) && !rst;
  assign done         = (state_q == FINISH) && !rst;
  assign err          = done && (tmask_q != '0);
  assign child_start  = rst ? '0 : start_c;
  assign done_mask    = done_mask_q;
  assign timeout_mask = tmask_q;

endmodule

// File: tb/tb_hier_node_sequencer.sv
module tb_hier_node_sequencer;

  localparam int N   = 5;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic         mode;
  logic [N-1:0] child_en;
  logic [N-1:0] child_start;
  logic [N-1:0] child_done;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] done_mask;
  logic [N-1:0] timeout_mask;

  hier_node_sequencer #(.NUM_CHILDREN(N), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .mode        (mode),
    .child_en    (child_en),
    .child_start (child_start),
    .child_done  (child_done),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .done_mask   (done_mask),
    .timeout_mask(timeout_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks = 0;
  int nerr    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected run completions.
  typedef struct {
    int           cyc;
    logic         err;
    logic [N-1:0] dm;
    logic [N-1:0] tm;
  } sb_t;
  sb_t sb[$];

  // Child responder: child i answers lat[i] cycles after its start (0 = never).
  // inj_mask is OR-ed into child_done in cycle inj_at for spurious pulses.
  logic [N-1:0][3:0] lat;
  int                rem [N];
  int                inj_at   = -1;
  logic [N-1:0]      inj_mask = '0;

  initial begin
    logic [N-1:0] cd;
    child_done = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    forever begin
      @(negedge clk);
      cd = '0;
      for (int i = 0; i < N; i++) begin
        if (rst) rem[i] = 0;
        else begin
          if (rem[i] > 0) begin
            rem[i]--;
            if (rem[i] == 0) cd[i] = 1'b1;
          end
          if (child_start[i] && lat[i] != 0) rem[i] = int'(lat[i]);
        end
      end
      if (cyc == inj_at) cd = cd | inj_mask;
      child_done = cd;
    end
  end

  // Monitor: start statistics and done-pulse scoreboard comparison.
  logic [N-1:0] starts_or = '0;
  int           nstarts   = 0;

  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (child_start != '0) begin
          starts_or = starts_or | child_start;
          nstarts++;
        end
        if (done) begin
          if (sb.size() == 0) check("done_unexpected", 32'(done), 32'd0);
          else begin
            e = sb.pop_front();
            check("done_cycle",   cyc,                e.cyc);
            check("err",          32'(err),           32'(e.err));
            check("done_mask",    32'(done_mask),     32'(e.dm));
            check("timeout_mask", 32'(timeout_mask),  32'(e.tm));
          end
        end
      end
    end
  end

  typedef struct packed {
    logic              mode;
    logic [N-1:0]      en;
    logic [N-1:0][3:0] lat;
    int                latency;   // done cycle minus accept cycle
    logic              err;
    logic [N-1:0]      dm;
    logic [N-1:0]      tm;
    logic [N-1:0]      starts;    // OR of all child_start seen in the run
    int                nstarts;   // cycles with a nonzero child_start
  } vec_t;

  vec_t vecs [8];

  task automatic wait_ready(input string name);
    for (int k = 0; k < 50 && !start_ready; k++) @(negedge clk);
    check(name, 32'(start_ready), 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  t;
    sb_t e;
    wait_ready("vec_ready_wait");
    lat         = v.lat;
    mode        = v.mode;
    child_en    = v.en;
    start_valid = 1'b1;
    starts_or   = '0;
    nstarts     = 0;
    t           = cyc;
    e.cyc = t + v.latency; e.err = v.err; e.dm = v.dm; e.tm = v.tm;
    sb.push_back(e);
    @(negedge clk);
    start_valid = 1'b0;
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    check($sformatf("v%0d_done_seen", idx), 32'(done), 32'd1);
    if (!done) sb.delete();
    check($sformatf("v%0d_ready_at_done", idx), 32'(start_ready), 32'd0);
    check($sformatf("v%0d_starts", idx), 32'(starts_or), 32'(v.starts));
    check($sformatf("v%0d_nstarts", idx), nstarts, v.nstarts);
    @(negedge clk);
    check($sformatf("v%0d_ready_after", idx), 32'(start_ready), 32'd1);
    check($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    sb_t e;
    //          mode  en        lat (idx4..idx0)                         lat err dm        tm        starts    n
    vecs[0] = '{1'b1, 5'b11111, {4'd4, 4'd7, 4'd2, 4'd5, 4'd3},           9, 1'b0, 5'b11111, 5'b00000, 5'b11111, 1};
    vecs[1] = '{1'b0, 5'b10110, {4'd2, 4'd2, 4'd2, 4'd2, 4'd2},          10, 1'b0, 5'b10110, 5'b00000, 5'b10110, 3};
    vecs[2] = '{1'b1, 5'b11111, {4'd4, 4'd0, 4'd3, 4'd2, 4'd1},          10, 1'b1, 5'b10111, 5'b01000, 5'b11111, 1};
    vecs[3] = '{1'b0, 5'b00111, {4'd0, 4'd0, 4'd2, 4'd0, 4'd2},          13, 1'b1, 5'b00001, 5'b00110, 5'b00011, 2};
    vecs[4] = '{1'b1, 5'b00000, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0},           1, 1'b0, 5'b00000, 5'b00000, 5'b00000, 0};
    vecs[5] = '{1'b1, 5'b00001, {4'd0, 4'd0, 4'd0, 4'd0, 4'd8},          10, 1'b0, 5'b00001, 5'b00000, 5'b00001, 1};
    vecs[6] = '{1'b0, 5'b00001, {4'd0, 4'd0, 4'd0, 4'd0, 4'd9},          10, 1'b1, 5'b00000, 5'b00001, 5'b00001, 1};
    vecs[7] = '{1'b0, 5'b11000, {4'd3, 4'd1, 4'd0, 4'd0, 4'd0},           7, 1'b0, 5'b11000, 5'b00000, 5'b11000, 2};

    rst = 1'b1; start_valid = 1'b0; mode = 1'b0; child_en = '0; lat = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_child_start",  32'(child_start),  32'd0);
    check("rst_done",         32'(done),         32'd0);
    check("rst_err",          32'(err),          32'd0);
    check("rst_busy",         32'(busy),         32'd0);
    check("rst_done_mask",    32'(done_mask),    32'd0);
    check("rst_timeout_mask", 32'(timeout_mask), 32'd0);
    check("rst_ready_low",    32'(start_ready),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_high",   32'(start_ready),  32'd1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Back-to-back empty-mask runs with start_valid held high.
    wait_ready("b2b_ready_wait");
    lat = '0; mode = 1'b0; child_en = '0; start_valid = 1'b1;
    t = cyc;
    e.err = 1'b0; e.dm = '0; e.tm = '0;
    e.cyc = t + 1; sb.push_back(e);
    e.cyc = t + 3; sb.push_back(e);
    @(negedge clk);
    check("b2b_ready_t1", 32'(start_ready), 32'd0);
    @(negedge clk);
    check("b2b_ready_t2", 32'(start_ready), 32'd1);
    @(negedge clk);
    start_valid = 1'b0;
    check("b2b_done_t3",  32'(done), 32'd1);
    @(negedge clk);
    check("b2b_ready_t4", 32'(start_ready), 32'd1);
    check("b2b_sb_empty", sb.size(), 0);

    // Spurious/duplicate done pulses, then reset mid-WAIT.
    wait_ready("abort_ready_wait");
    lat = {4'd0, 4'd0, 4'd0, 4'd0, 4'd2};
    mode = 1'b1; child_en = 5'b01111; start_valid = 1'b1;
    starts_or = '0; nstarts = 0;
    t = cyc;
    inj_mask = 5'b00010; inj_at = t + 1;        // same cycle as its start
    @(negedge clk);
    start_valid = 1'b0;
    while (cyc < t + 2) @(negedge clk);
    inj_mask = 5'b10001; inj_at = t + 4;        // disabled child + duplicate
    while (cyc < t + 5) @(negedge clk);
    check("abort_live_done_mask", 32'(done_mask), 32'b00001);
    check("abort_live_busy",      32'(busy),      32'd1);
    @(negedge clk);
    rst = 1'b1;
    inj_mask = 5'b00001; inj_at = t + 7;        // late done during reset
    #1;
    check("abort_busy",        32'(busy),        32'd0);
    check("abort_child_start", 32'(child_start), 32'd0);
    check("abort_done",        32'(done),        32'd0);
    check("abort_ready",       32'(start_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort_done_mask",    32'(done_mask),    32'd0);
    check("abort_timeout_mask", 32'(timeout_mask), 32'd0);
    check("abort_err",          32'(err),          32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready_release", 32'(start_ready), 32'd1);
    repeat (15) @(negedge clk);
    check("abort_nstarts",  nstarts, 1);
    check("abort_idle",     32'(busy), 32'd0);
    check("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
